// File: rtl/stack_mem_master_pkg.sv
// stack_mem_master_pkg: MEM port widths and stack master FSM state encoding
package stack_mem_master_pkg;
  localparam int MEM_ADDR_W = 5;
  localparam int MEM_DATA_W = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_W_SETUP,
    S_W_STROBE,
    S_W_HOLD,
    S_R_ADDR,
    S_R_CAPT
  } state_t;
endpackage

// File: rtl/stack_mem_master.sv
// stack_mem_master: sequences stack push/pop commands into setup/strobe/hold MEM accesses
module stack_mem_master
  import stack_mem_master_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter logic [ADDR_W-1:0] BASE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              push_done,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state, state_n;
  logic [ADDR_W:0] count_n;
  logic [ADDR_W-1:0] adr_n;
  logic [DATA_W-1:0] wdata_n, pop_data_n;
  logic write_n, read_n, pop_valid_n, push_done_n, err_n;
  assign busy = state != S_IDLE;
  assign full = count[ADDR_W];
  assign empty = count == '0;
  // Address, data and the read strobe persist unless a state changes them
  always_comb begin
    state_n = state;
    count_n = count;
    adr_n = mem_adr;
    wdata_n = mem_wdata;
    write_n = 1'b0;
    read_n = mem_read;
    pop_data_n = pop_data;
    pop_valid_n = 1'b0;
    push_done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      S_IDLE:
        if (push && !pop && !full) begin
          adr_n = BASE + count[ADDR_W-1:0];
          wdata_n = push_data;
          state_n = S_W_SETUP;
        end else if (pop && !push && !empty) begin
          adr_n = BASE + count[ADDR_W-1:0] - ADDR_W'(1);
          read_n = 1'b1;
          state_n = S_R_ADDR;
        end else
          err_n = push | pop;
      S_W_SETUP: begin
        write_n = 1'b1;
        state_n = S_W_STROBE;
      end
      S_W_STROBE: begin
        count_n = count + (ADDR_W+1)'(1);
        push_done_n = 1'b1;
        state_n = S_W_HOLD;
      end
      S_W_HOLD: state_n = S_IDLE;
      S_R_ADDR: state_n = S_R_CAPT;
      S_R_CAPT: begin
        pop_data_n = mem_rdata;
        read_n = 1'b0;
        count_n = count - (ADDR_W+1)'(1);
        pop_valid_n = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      count <= '0;
      mem_adr <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read <= 1'b0;
      pop_data <= '0;
      pop_valid <= 1'b0;
      push_done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      mem_adr <= adr_n;
      mem_wdata <= wdata_n;
      mem_write <= write_n;
      mem_read <= read_n;
      pop_data <= pop_data_n;
      pop_valid <= pop_valid_n;
      push_done <= push_done_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_stack_mem_master.sv
// tb_stack_mem_master: two masters (BASE 0 and 30) with MEM models, checked against a stack model
module tb_stack_mem_master;
  import stack_mem_master_pkg::*;
  localparam int D = 1 << MEM_ADDR_W;
  logic clk = 0, rst = 1, push = 0, pop = 0;
  logic [7:0] push_data = 0;
  logic [7:0] pop_data [2], mem_wdata [2], mem_rdata [2];
  logic [4:0] mem_adr [2];
  logic [5:0] count [2];
  logic pop_valid [2], push_done [2], busy [2], err [2], full [2], empty [2];
  logic mem_write [2], mem_read [2];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : inst
    logic [7:0] mem [D];
    stack_mem_master #(.BASE(g ? 5'd30 : 5'd0)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
      .pop_data(pop_data[g]), .pop_valid(pop_valid[g]), .push_done(push_done[g]),
      .busy(busy[g]), .err(err[g]), .count(count[g]), .full(full[g]), .empty(empty[g]),
      .mem_adr(mem_adr[g]), .mem_wdata(mem_wdata[g]), .mem_write(mem_write[g]),
      .mem_read(mem_read[g]), .mem_rdata(mem_rdata[g])
    );
    initial for (int i = 0; i < D; i++) mem[i] = 8'h00;
    always @(posedge clk) if (mem_write[g]) mem[mem_adr[g]] <= mem_wdata[g];
    assign mem_rdata[g] = mem[mem_adr[g]];
  end
  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction
  // Transaction-level model: age counts edges since a command was accepted
  int age = 0, cnt = 0;
  bit is_push = 0, en = 0;
  logic [7:0] stk [$];
  logic [7:0] e_wdata = 0, e_pop_data = 0;
  int e_adr [2] = '{0, 0};
  bit e_wr = 0, e_rd = 0, e_pv = 0, e_pd = 0, e_err = 0;
  task automatic set_adr(input int i);
    e_adr[0] = i % D;
    e_adr[1] = (30 + i) % D;
  endtask
  initial forever begin
    @(posedge clk);
    if (rst) begin
      age = 0; cnt = 0; stk.delete(); e_adr = '{0, 0}; e_wdata = 0; e_pop_data = 0;
      e_wr = 0; e_rd = 0; e_pv = 0; e_pd = 0; e_err = 0; en = 1;
    end else begin
      e_pv = 0; e_pd = 0; e_err = 0;
      if (age == 0) begin
        if (push && !pop && cnt < D) begin
          is_push = 1; age = 1; e_wdata = push_data; set_adr(cnt);
        end else if (pop && !push && cnt > 0) begin
          is_push = 0; age = 1; e_rd = 1; set_adr(cnt - 1);
        end else e_err = push | pop;
      end else begin
        age++;
        if (is_push) begin
          e_wr = (age == 2);
          if (age == 3) begin cnt++; stk.push_back(e_wdata); e_pd = 1; end
          if (age == 4) age = 0;
        end else if (age == 3) begin
          e_pop_data = stk.pop_back(); e_rd = 0; cnt--; e_pv = 1; age = 0;
        end
      end
    end
  end
  always @(negedge clk) if (en) for (int g = 0; g < 2; g++) begin
    chk($sformatf("u%0d.busy", g), busy[g], age != 0);
    chk($sformatf("u%0d.count", g), count[g], cnt);
    chk($sformatf("u%0d.full", g), full[g], cnt == D);
    chk($sformatf("u%0d.empty", g), empty[g], cnt == 0);
    chk($sformatf("u%0d.mem_adr", g), mem_adr[g], e_adr[g]);
    chk($sformatf("u%0d.mem_wdata", g), mem_wdata[g], e_wdata);
    chk($sformatf("u%0d.mem_write", g), mem_write[g], e_wr);
    chk($sformatf("u%0d.mem_read", g), mem_read[g], e_rd);
    chk($sformatf("u%0d.pop_data", g), pop_data[g], e_pop_data);
    chk($sformatf("u%0d.pop_valid", g), pop_valid[g], e_pv);
    chk($sformatf("u%0d.push_done", g), push_done[g], e_pd);
    chk($sformatf("u%0d.err", g), err[g], e_err);
  end
  task automatic wait_idle();
    int n = 0;
    while (busy[0] && n < 16) begin @(negedge clk); n++; end
    if (busy[0]) begin
      tests++; fails++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles", n);
    end
  endtask
  task automatic cmd(input bit p, input bit q, input logic [7:0] d);
    push = p; pop = q; push_data = d;
    @(negedge clk);
    push = 0; pop = 0;
    wait_idle();
  endtask
  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    chk("lit_reset_count", count[0], 0);
    chk("lit_reset_empty", empty[0], 1);
    cmd(1, 0, 8'hAA);
    chk("lit_mem0_AA", inst[0].mem[0], 8'hAA);
    chk("lit_count1", count[0], 1);
    cmd(1, 0, 8'hF0);
    cmd(0, 1, 0);
    chk("lit_pop_F0", pop_data[0], 8'hF0);
    cmd(0, 1, 0);
    chk("lit_pop_AA", pop_data[0], 8'hAA);
    chk("lit_empty", empty[0], 1);
    pop = 1;
    @(negedge clk);
    pop = 0;
    chk("lit_err_empty_pop", err[0], 1);
    wait_idle();
    do_reset();
    for (int i = 0; i < D; i++) cmd(1, 0, 8'(i));
    chk("lit_full", full[0], 1);
    cmd(1, 0, 8'h77);
    cmd(0, 1, 0);
    chk("lit_pop_31", pop_data[0], 31);
    do_reset();
    for (int i = 1; i <= 3; i++) cmd(1, 0, 8'(i));
    chk("lit_b30_mem30", inst[1].mem[30], 1);
    chk("lit_b30_mem31", inst[1].mem[31], 2);
    chk("lit_b30_mem0", inst[1].mem[0], 3);
    for (int i = 0; i < 3; i++) cmd(0, 1, 0);
    chk("lit_b30_last_pop", pop_data[1], 1);
    cmd(1, 0, 8'h11);
    push = 1; push_data = 8'h22;
    @(negedge clk);
    push = 0;
    @(negedge clk);
    chk("lit_strobe_write", mem_write[0], 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("lit_rst_write", mem_write[0], 0);
    chk("lit_rst_busy", busy[0], 0);
    chk("lit_rst_count", count[0], 0);
    cmd(1, 1, 8'h55);
    push = 1; push_data = 8'h66;
    repeat (6) @(negedge clk);
    push = 0;
    wait_idle();
    repeat (3000) begin
      rst = $urandom_range(0, 199) == 0;
      push = $urandom_range(0, 2) == 0;
      pop = $urandom_range(0, 2) == 0;
      push_data = 8'($urandom);
      @(negedge clk);
    end
    rst = 0; push = 0; pop = 0;
    repeat (6) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
